maxpooling: RTL and testbench
=============================

Name: maxpooling

Overview:
- Streaming 2x2, stride-2 max-pooling block for the CNN datapath; sits after the sigmoid/activation stage.
- Consumes one signed pixel per enabled cycle: CH feature maps of IN_W x IN_W in raster order (channel, row, column).
- Emits CH maps of (IN_W/2) x (IN_W/2) window maxima in the same order, with frame/line framing and a valid strobe.
- Bench-side signal bundle is interface maxpooling_if.

Parameters:
- DATA_W, 16: signed pixel width for input and output.
- IN_W, 28: input map width and height; must be even.
- CH, 5: channels per frame.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset; synchronous, active-high (the name is kept from the codebase; 1 = reset).
- ena, input, 1: sig_layer carries a valid pixel this cycle.
- frame_start_in, input, 1: one-cycle pulse before the first pixel of a frame; ena is 0 in that cycle.
- line_start_in, input, 1: pulses with the last pixel of each input row, except the frame's final pixel.
- frame_end_in, input, 1: pulses with the frame's final pixel.
- sig_layer, input, DATA_W: signed input pixel.
- max_layer, output, DATA_W: signed 2x2 window maximum.
- frame_start_out, output, 1: registered copy of frame_start_in.
- line_start_out, output, 1: high with the first valid output of each output row.
- frame_end_out, output, 1: high with the final valid output of the frame.
- valid, output, 1: max_layer holds a result.

Behaviour:
- Reset (rst_n=1 at a clock edge): all outputs go to 0; column, row and channel counters clear; takes priority over all other inputs; may occur mid-frame, after which the block waits for the next frame_start_in.
- frame_start_in=1: clears the column and row counters and the pending-output state. frame_start_out is asserted in the next cycle for one cycle.
- Pixel acceptance: a pixel is accepted only when ena=1. With ena=0, all state holds and valid=0.
- Column counter: col runs 0..IN_W-1 and wraps to 0. Row counter: row runs 0..IN_W-1 and wraps to 0, which starts the next channel.
- line_start_in resynchronises: after an accepted pixel with line_start_in=1, the next pixel has col=0 regardless of count.
- Horizontal pair: at odd col, hmax = signed max(previous pixel, current pixel).
- Even row, odd col: store hmax in line buffer entry col/2. The buffer has IN_W/2 entries of DATA_W bits.
- Odd row, odd col: result = signed max(hmax, buffer[col/2]). Registered output: valid=1 and max_layer=result in the cycle after the pixel is accepted (latency 1).
- Output count: exactly IN_W/2 valids per output row, CH*(IN_W/2)^2 = 980 per frame at defaults, in (channel, row, col) order.
- All comparisons are two's-complement signed; ties give the equal value; no saturation or width change.
- line_start_out: asserted with the valid for output column 0.
- frame_end_out: the registered frame_end_in, i.e. asserted in the same cycle as the last valid. No valid follows frame_end_out until the next frame_start_in.
- Unless a bit is defined as a pulse above, it is 0 in every cycle. max_layer holds its last value when valid=0.
- Gaps of ena=0 anywhere in a row only stretch timing; results are unaffected.

Decomposition:
- Package maxpooling_pkg: DATA_W, IN_W, CH and OUT_W = IN_W/2 constants; typedef pixel_t = logic signed [DATA_W-1:0]; signed max function.
- Natural sub-module: maxpool_line_buffer, an OUT_W x DATA_W register array with write/read at index col/2.
- maxpooling_if carries all DUT ports except clk and rst_n, plus clocking block cb on posedge clk.

Test Plan:
- Random full frame: 5x28x28 random signed 16-bit values, continuous ena -> 980 valids in raster order matching a reference 2x2 max model; frame_end_out coincides with valid #980.
- Sign handling: window {-5, -3, -32768, -7} -> -3. Window {32767, -1, 0, 1} -> 32767.
- Latency: 2x2 window with pixel (1,1)=100 and the others 0, continuous ena -> valid with max_layer=100 exactly one cycle after (1,1) is accepted; line_start_out high with it.
- ena gaps: same frame as the random test with ena=0 inserted every third cycle -> identical result sequence; valid=0 during gaps.
- Mid-frame reset: reset asserted after 300 pixels, then a full new frame -> all outputs 0 during reset; the new frame yields exactly 980 correct results.
- Back-to-back frames: second frame_start_in immediately after frame_end_in -> frame_start_out pulse, counters restart, second frame correct.

Source files
------------

// File: rtl/maxpooling_pkg.sv
// Shared constants, pixel type and signed max helper for the 2x2/stride-2
// max-pooling block and its line buffer.
package maxpooling_pkg;
   localparam int unsigned DATA_W = 16;            // signed pixel width
   localparam int unsigned IN_W   = 28;            // input map width/height (even)
   localparam int unsigned CH     = 5;             // channels per frame
   localparam int unsigned OUT_W  = IN_W / 2;      // output map width/height

   localparam int unsigned COL_W  = $clog2(IN_W);  // col/row counter width
   localparam int unsigned IDX_W  = COL_W - 1;     // line buffer index = col/2
   localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);

   typedef logic signed [DATA_W-1:0] pixel_t;

   // Two's-complement maximum; ties return the (equal) value.
   function automatic pixel_t smax(input pixel_t a, input pixel_t b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/maxpool_line_buffer.sv
// Holds the horizontal pair maxima of an even input row so the following odd
// row can complete each 2x2 window.
// Ports:
//   clk     - clock, rising edge
//   we_i    - write enable (even row, odd column)
//   idx_i   - entry index, col/2; shared by write and read
//   wdata_i - horizontal pair maximum to store
//   rdata_o - stored entry at idx_i (combinational read)
module maxpool_line_buffer
   import maxpooling_pkg::*;
(
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [IDX_W-1:0]         idx_i,
   input  logic signed [DATA_W-1:0] wdata_i,
   output logic signed [DATA_W-1:0] rdata_o
);

   pixel_t mem_q [OUT_W];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/maxpooling.sv
// Streaming 2x2, stride-2 max pooling over CH maps of IN_W x IN_W signed
// pixels in (channel, row, column) raster order. One result per window,
// registered, one cycle after the window's bottom-right pixel is accepted.
// Ports:
//   clk             - clock, rising edge
//   rst_n           - synchronous reset, ACTIVE HIGH (legacy name)
//   ena             - sig_layer carries a valid pixel
//   frame_start_in  - pulse before the first pixel of a frame
//   line_start_in   - with the last pixel of each input row (not frame's last)
//   frame_end_in    - with the frame's final pixel
//   sig_layer       - signed input pixel
//   max_layer       - signed window maximum (held while valid=0)
//   frame_start_out - registered frame_start_in
//   line_start_out  - with the valid of output column 0
//   frame_end_out   - with the frame's final valid
//   valid           - max_layer holds a new result
module maxpooling
   import maxpooling_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     frame_start_in,
   input  logic                     line_start_in,
   input  logic                     frame_end_in,
   input  logic signed [DATA_W-1:0] sig_layer,
   output logic signed [DATA_W-1:0] max_layer,
   output logic                     frame_start_out,
   output logic                     line_start_out,
   output logic                     frame_end_out,
   output logic                     valid
);

   logic [COL_W-1:0] col_q, col_d;
   logic [COL_W-1:0] row_q, row_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   // Pixels are only taken between frame_start_in and frame_end_in; after a
   // reset the block ignores ena until the next frame_start_in.
   logic             active_q, active_d;
   pixel_t           prev_q, prev_d;

   pixel_t           max_q, max_d;
   logic             valid_q, valid_d;
   logic             ls_q, ls_d;
   logic             fe_q, fe_d;
   logic             fs_q, fs_d;

   logic             buf_we;
   logic [IDX_W-1:0] buf_idx;
   pixel_t           hmax;
   pixel_t           buf_rd;

   assign buf_idx = col_q[COL_W-1:1];
   assign hmax    = smax(prev_q, sig_layer);

   maxpool_line_buffer u_line_buffer (
      .clk     (clk),
      .we_i    (buf_we),
      .idx_i   (buf_idx),
      .wdata_i (hmax),
      .rdata_o (buf_rd)
   );

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      ch_d     = ch_q;
      active_d = active_q;
      prev_d   = prev_q;
      max_d    = max_q;
      valid_d  = 1'b0;
      ls_d     = 1'b0;
      fe_d     = 1'b0;
      fs_d     = frame_start_in;
      buf_we   = 1'b0;

      if (frame_start_in) begin
         col_d    = '0;
         row_d    = '0;
         ch_d     = '0;
         active_d = 1'b1;
      end else if (ena && active_q) begin
         prev_d = sig_layer;
         if (col_q[0]) begin
            if (!row_q[0]) begin
               buf_we = 1'b1;
            end else begin
               valid_d = 1'b1;
               max_d   = smax(hmax, buf_rd);
               ls_d    = (buf_idx == '0);
            end
         end
         // line_start_in forces a row change even if the count disagrees
         if (line_start_in || (col_q == COL_LAST)) begin
            col_d = '0;
            if (row_q == COL_LAST) begin
               row_d = '0;
               ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
         if (frame_end_in) begin
            fe_d     = 1'b1;
            active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         col_q    <= '0;
         row_q    <= '0;
         ch_q     <= '0;
         active_q <= 1'b0;
         prev_q   <= '0;
         max_q    <= '0;
         valid_q  <= 1'b0;
         ls_q     <= 1'b0;
         fe_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         ch_q     <= ch_d;
         active_q <= active_d;
         prev_q   <= prev_d;
         max_q    <= max_d;
         valid_q  <= valid_d;
         ls_q     <= ls_d;
         fe_q     <= fe_d;
         fs_q     <= fs_d;
      end
   end

   assign max_layer       = max_q;
   assign valid           = valid_q;
   assign line_start_out  = ls_q;
   assign frame_end_out   = fe_q;
   assign frame_start_out = fs_q;

endmodule

// File: tb/tb_maxpooling.sv
// Directed/self-checking bench for maxpooling: a frame-level 2x2 max model
// builds the expected result queue, one process compares every cycle.
module tb_maxpooling;
   import maxpooling_pkg::*;

   localparam int W     = IN_W;
   localparam int NC    = CH;
   localparam int OW    = OUT_W;
   localparam int TOTAL = NC * W * W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n = 1'b1;
   logic                     ena = 1'b0;
   logic                     frame_start_in = 1'b0;
   logic                     line_start_in = 1'b0;
   logic                     frame_end_in = 1'b0;
   logic signed [DATA_W-1:0] sig_layer = '0;
   logic signed [DATA_W-1:0] max_layer;
   logic                     frame_start_out;
   logic                     line_start_out;
   logic                     frame_end_out;
   logic                     valid;

   maxpooling dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ena             (ena),
      .frame_start_in  (frame_start_in),
      .line_start_in   (line_start_in),
      .frame_end_in    (frame_end_in),
      .sig_layer       (sig_layer),
      .max_layer       (max_layer),
      .frame_start_out (frame_start_out),
      .line_start_out  (line_start_out),
      .frame_end_out   (frame_end_out),
      .valid           (valid)
   );

   typedef struct {
      int val;
      bit ls;
      bit fe;
   } exp_t;

   exp_t   expq[$];
   int     fr [NC][W][W];
   int     log_val[$];
   bit     log_ls[$];
   longint log_edge[$];
   int     saved_val[$];
   longint edge_cnt = 0;
   longint lat_edge = -1;
   int     exp_cnt;
   int     vectors = 0;
   int     miscompares = 0;

   task automatic chk(input string nm, input longint act, input longint want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Expected results of windows whose last pixel index is below limit.
   task automatic build_expected(input int limit);
      exp_t e;
      int   idx;
      exp_cnt = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < OW; r++)
            for (int k = 0; k < OW; k++) begin
               idx = c*W*W + (2*r+1)*W + 2*k + 1;
               if (idx < limit) begin
                  e.val = max2(max2(fr[c][2*r][2*k], fr[c][2*r][2*k+1]),
                               max2(fr[c][2*r+1][2*k], fr[c][2*r+1][2*k+1]));
                  e.ls  = (k == 0);
                  e.fe  = (limit >= TOTAL) && (c == NC-1) && (r == OW-1) && (k == OW-1);
                  expq.push_back(e);
                  exp_cnt++;
               end
            end
   endtask

   task automatic randomize_frame();
      logic [15:0] rv;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < W; r++)
            for (int k = 0; k < W; k++) begin
               rv = 16'($urandom);
               if ($urandom_range(0, 15) == 0) rv = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
               fr[c][r][k] = int'($signed(rv));
            end
   endtask

   task automatic send_frame(input bit gaps, input int limit);
      int cyc = 0;
      int c, r, k;
      build_expected(limit);
      log_val.delete(); log_ls.delete(); log_edge.delete();
      @(negedge clk);
      frame_start_in = 1'b1; ena = 1'b0; line_start_in = 1'b0; frame_end_in = 1'b0;
      @(negedge clk);
      frame_start_in = 1'b0;
      for (int idx = 0; idx < TOTAL; idx++) begin
         if (idx >= limit) break;
         if (gaps && (cyc % 3 == 2)) begin
            ena = 1'b0; line_start_in = 1'b0; frame_end_in = 1'b0;
            @(negedge clk);
            cyc++;
         end
         c = idx / (W*W); r = (idx / W) % W; k = idx % W;
         ena           = 1'b1;
         sig_layer     = 16'(fr[c][r][k]);
         line_start_in = (k == W-1) && (idx != TOTAL-1);
         frame_end_in  = (idx == TOTAL-1);
         if (c == 0 && r == 3 && k == 1) lat_edge = edge_cnt + 1;
         @(negedge clk);
         cyc++;
      end
      ena = 1'b0; line_start_in = 1'b0; frame_end_in = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 5 && expq.size() != 0; i++) @(negedge clk);
      chk({nm, "_drain"}, expq.size(), 0);
      chk({nm, "_count"}, log_val.size(), exp_cnt);
      expq.delete();
   endtask

   // Per-cycle compare process, sampling 1 time unit after each rising edge.
   initial begin : compare
      bit s_rst, s_ena, s_fs;
      int last_max = 0;
      exp_t e;
      forever begin
         @(posedge clk);
         edge_cnt++;
         s_rst = rst_n; s_ena = ena; s_fs = frame_start_in;
         #1;
         if (s_rst) begin
            chk("reset_outputs", {valid, line_start_out, frame_end_out, frame_start_out, max_layer}, 0);
            last_max = 0;
         end else begin
            chk("frame_start_out", frame_start_out, s_fs);
            if (!s_ena) chk("valid_without_ena", valid, 0);
            if (valid) begin
               if (expq.size() == 0) begin
                  chk("valid_unexpected", valid, 0);
               end else begin
                  e = expq.pop_front();
                  chk("max_layer", int'(max_layer), e.val);
                  chk("line_start_out", line_start_out, e.ls);
                  chk("frame_end_out", frame_end_out, e.fe);
               end
               log_val.push_back(int'(max_layer));
               log_ls.push_back(line_start_out);
               log_edge.push_back(edge_cnt);
               last_max = int'(max_layer);
            end else begin
               chk("idle_framing", {line_start_out, frame_end_out}, 0);
               chk("max_hold", int'(max_layer), last_max);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Literal windows pinning sign handling and latency.
      randomize_frame();
      fr[0][0][0] = -5;     fr[0][0][1] = -3;  fr[0][1][0] = -32768; fr[0][1][1] = -7;
      fr[0][0][2] = 32767;  fr[0][0][3] = -1;  fr[0][1][2] = 0;      fr[0][1][3] = 1;
      fr[0][2][0] = 0;      fr[0][2][1] = 0;   fr[0][3][0] = 0;      fr[0][3][1] = 100;
      build_expected(TOTAL);
      chk("model_neg_window", expq[0].val, -3);
      chk("model_pos_window", expq[1].val, 32767);
      chk("model_latency_window", expq[OW].val, 100);
      expq.delete();
      send_frame(1'b0, TOTAL);
      drain("literal");
      chk("lit_neg_window", log_val[0], -3);
      chk("lit_pos_window", log_val[1], 32767);
      chk("lit_latency_value", log_val[OW], 100);
      chk("lit_latency_edge", log_edge[OW], lat_edge);
      chk("lit_latency_ls", log_ls[OW], 1);

      // Random frame, continuous then with ena gaps: identical results.
      randomize_frame();
      send_frame(1'b0, TOTAL);
      drain("random");
      saved_val = log_val;
      send_frame(1'b1, TOTAL);
      drain("gaps");
      for (int i = 0; i < saved_val.size() && i < log_val.size(); i++)
         if (log_val[i] != saved_val[i]) chk("gap_sequence", log_val[i], saved_val[i]);
      chk("gap_sequence_len", log_val.size(), saved_val.size());

      // Reset after 300 pixels; stray pixels before the next frame_start.
      send_frame(1'b0, 300);
      drain("partial");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ena = 1'b1; sig_layer = 16'($urandom);
         @(negedge clk);
      end
      ena = 1'b0;
      randomize_frame();
      send_frame(1'b0, TOTAL);
      drain("after_reset");

      // Back-to-back frames.
      randomize_frame();
      send_frame(1'b0, TOTAL);
      chk("b2b_first_count", log_val.size(), exp_cnt);
      randomize_frame();
      send_frame(1'b0, TOTAL);
      drain("b2b_second");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
